// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps rising edges of a neuron spike output,
// queues {timestamp, membrane state} snapshots in a small FIFO, and
// reports the spike count of each completed 256-cycle window.
module spike_event_logger #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spike_in,
  input  logic [7:0] state_in,
  input  logic       clr,
  input  logic       pop,
  output logic       evt_valid,
  output logic [7:0] evt_ts,
  output logic [7:0] evt_state,
  output logic       overflow,
  output logic [7:0] rate,
  output logic       rate_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0] ts;
    logic [7:0] state;
  } entry_t;

  logic [7:0]    tsCnt_q, tsCnt_d;
  logic          spk_q;
  logic [7:0]    winCnt_q, winCnt_d;
  logic [7:0]    rate_q, rate_d;
  logic          rateValid_q, rateValid_d;
  logic          overflow_q, overflow_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          headValid_q, headValid_d;
  entry_t        head_q, head_d;

  logic spikeEvent;
  logic popAccept;
  logic fifoFull;
  logic doPush;
  logic dropEvent;

  // A spike is a 0->1 transition between the previous and current sample;
  // a full FIFO still accepts an event when the head leaves on the same edge.
  assign spikeEvent = spike_in & ~spk_q;
  assign popAccept  = pop & (count_q != '0);
  assign fifoFull   = (count_q == CW'(DEPTH));
  assign doPush     = spikeEvent & (~fifoFull | popAccept);
  assign dropEvent  = spikeEvent & fifoFull & ~popAccept;

  // Next-state for timestamp, window counter, flags and FIFO, plus the head
  // entry that will be visible after this edge (so a push shows up at once).
  always_comb begin
    mem_d       = mem_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    tsCnt_d     = tsCnt_q + 8'd1;
    winCnt_d    = winCnt_q;
    rate_d      = rate_q;
    rateValid_d = 1'b0;

    if (clr) begin
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      tsCnt_d    = 8'd0;
      winCnt_d   = 8'd0;
      rate_d     = 8'd0;
    end else begin
      if (doPush) begin
        mem_d[wrPtr_q] = '{ts: tsCnt_q, state: state_in};
        wrPtr_d        = wrPtr_q + PW'(1);
      end
      if (popAccept) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      if (dropEvent) begin
        overflow_d = 1'b1;
      end
      count_d = count_q + {{(CW-1){1'b0}}, doPush} - {{(CW-1){1'b0}}, popAccept};

      if (tsCnt_q == 8'hFF) begin
        rate_d      = winCnt_q + {7'd0, spikeEvent};
        winCnt_d    = 8'd0;
        rateValid_d = 1'b1;
      end else begin
        winCnt_d = winCnt_q + {7'd0, spikeEvent};
      end
    end

    headValid_d = (count_d != '0);
    head_d      = headValid_d ? mem_d[rdPtr_d] : '0;
  end

  // Control and output registers; reset wins over clear and all inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tsCnt_q     <= 8'd0;
      spk_q       <= 1'b0;
      winCnt_q    <= 8'd0;
      rate_q      <= 8'd0;
      rateValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      headValid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      tsCnt_q     <= tsCnt_d;
      spk_q       <= spike_in;
      winCnt_q    <= winCnt_d;
      rate_q      <= rate_d;
      rateValid_q <= rateValid_d;
      overflow_q  <= overflow_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      headValid_q <= headValid_d;
      head_q      <= head_d;
    end
  end

  // Entry storage; contents are only meaningful inside the occupied range.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign evt_valid  = headValid_q;
  assign evt_ts     = head_q.ts;
  assign evt_state  = head_q.state;
  assign overflow   = overflow_q;
  assign rate       = rate_q;
  assign rate_valid = rateValid_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Testbench for spike_event_logger: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_spike_event_logger;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spike_in;
  logic [7:0] state_in;
  logic       clr;
  logic       pop;
  logic       evt_valid;
  logic [7:0] evt_ts;
  logic [7:0] evt_state;
  logic       overflow;
  logic [7:0] rate;
  logic       rate_valid;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [15:0] mq[$];
  int          mTs;
  int          mWin;
  int          mRate;
  bit          mRv;
  bit          mOvf;
  bit          mPrev;

  spike_event_logger #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (spike_in),
    .state_in  (state_in),
    .clr       (clr),
    .pop       (pop),
    .evt_valid (evt_valid),
    .evt_ts    (evt_ts),
    .evt_state (evt_state),
    .overflow  (overflow),
    .rate      (rate),
    .rate_valid(rate_valid)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied to the DUT
  task automatic modelEdge();
    bit ev;
    bit popOk;
    bit room;
    if (!rst_n) begin
      mq.delete();
      mTs = 0; mWin = 0; mRate = 0; mRv = 0; mOvf = 0; mPrev = 0;
    end else begin
      ev    = spike_in && !mPrev;
      mPrev = spike_in;
      if (clr) begin
        mq.delete();
        mTs = 0; mWin = 0; mRate = 0; mRv = 0; mOvf = 0;
      end else begin
        popOk = pop && (mq.size() > 0);
        room  = (mq.size() < DEPTH) || popOk;
        if (popOk) void'(mq.pop_front());
        if (ev) begin
          if (room) mq.push_back({mTs[7:0], state_in});
          else mOvf = 1;
        end
        if (mTs == 255) begin
          mRate = mWin + int'(ev);
          mWin  = 0;
          mRv   = 1;
        end else begin
          mWin = mWin + int'(ev);
          mRv  = 0;
        end
        mTs = (mTs + 1) % 256;
      end
    end
  endtask

  task automatic checkOutput();
    logic [15:0] head;
    head = (mq.size() > 0) ? mq[0] : 16'h0000;
    checkVal("evt_valid", {7'd0, evt_valid}, (mq.size() > 0) ? 8'd1 : 8'd0);
    checkVal("evt_ts", evt_ts, head[15:8]);
    checkVal("evt_state", evt_state, head[7:0]);
    checkVal("overflow", {7'd0, overflow}, {7'd0, mOvf});
    checkVal("rate", rate, mRate[7:0]);
    checkVal("rate_valid", {7'd0, rate_valid}, {7'd0, mRv});
  endtask

  task automatic applyStimulus(input bit sp, input logic [7:0] st, input bit pp,
                               input bit cl, input bit rn);
    spike_in = sp;
    state_in = st;
    pop      = pp;
    clr      = cl;
    rst_n    = rn;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    int n;
    logic [7:0] lastTs;
    rst_n = 1'b0; spike_in = 1'b1; state_in = 8'h00; clr = 1'b0; pop = 1'b1;
    mTs = 0; mWin = 0; mRate = 0; mRv = 0; mOvf = 0; mPrev = 0;

    $display("[TB] reset with spike and pop held high");
    applyStimulus(1, 8'h11, 1, 0, 0);
    applyStimulus(1, 8'h22, 1, 0, 0);
    checkVal("rst_evt_valid", {7'd0, evt_valid}, 8'd0);
    checkVal("rst_rate", rate, 8'd0);
    applyStimulus(1, 8'h33, 0, 0, 1);
    checkVal("rel_evt_valid", {7'd0, evt_valid}, 8'd1);
    checkVal("rel_evt_ts", evt_ts, 8'h00);
    applyStimulus(0, 8'h00, 1, 0, 1);

    $display("[TB] single event at ts 10");
    n = 0;
    while (mTs != 10 && n < 300) begin
      applyStimulus(0, 8'h00, 0, 0, 1);
      n++;
    end
    applyStimulus(1, 8'h5A, 0, 0, 1);
    checkVal("single_valid", {7'd0, evt_valid}, 8'd1);
    checkVal("single_ts", evt_ts, 8'h0A);
    checkVal("single_state", evt_state, 8'h5A);
    applyStimulus(0, 8'h00, 1, 0, 1);
    checkVal("single_pop_valid", {7'd0, evt_valid}, 8'd0);
    checkVal("single_pop_ts", evt_ts, 8'h00);

    $display("[TB] level held high for five cycles");
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h70 + i), 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 1);
    n = 0;
    while (evt_valid && n < 8) begin
      applyStimulus(0, 8'h00, 1, 0, 1);
      n++;
    end
    checkVal("held_entries", 8'(n), 8'd1);

    $display("[TB] overflow with five events and no pop");
    applyStimulus(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'(i * 16 + 1), 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 1);
    end
    checkVal("ovf_flag", {7'd0, overflow}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      checkVal("ovf_head_ts", evt_ts, 8'(2 * i));
      applyStimulus(0, 8'h00, 1, 0, 1);
    end
    checkVal("ovf_drained", {7'd0, evt_valid}, 8'd0);
    checkVal("ovf_sticky", {7'd0, overflow}, 8'd1);
    applyStimulus(0, 8'h00, 0, 1, 1);
    checkVal("ovf_clr_flag", {7'd0, overflow}, 8'd0);
    checkVal("ovf_clr_valid", {7'd0, evt_valid}, 8'd0);

    $display("[TB] full FIFO with coincident push and pop");
    applyStimulus(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'(8'hA0 + i), 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 1);
    end
    applyStimulus(1, 8'hEE, 1, 0, 1);
    checkVal("pp_overflow", {7'd0, overflow}, 8'd0);
    n = 0;
    lastTs = 8'hFF;
    while (evt_valid && n < 8) begin
      lastTs = evt_ts;
      applyStimulus(0, 8'h00, 1, 0, 1);
      n++;
    end
    checkVal("pp_occupancy", 8'(n), 8'd4);
    checkVal("pp_last_ts", lastTs, 8'h08);

    $display("[TB] rate windows");
    applyStimulus(0, 8'h00, 0, 1, 1);
    n = 0;
    while (mTs != 100 && n < 300) begin applyStimulus(0, 8'h00, 0, 0, 1); n++; end
    applyStimulus(1, 8'h01, 0, 0, 1);
    while (mTs != 200 && n < 600) begin applyStimulus(0, 8'h00, 0, 0, 1); n++; end
    applyStimulus(1, 8'h02, 0, 0, 1);
    while (mTs != 255 && n < 900) begin applyStimulus(0, 8'h00, 0, 0, 1); n++; end
    applyStimulus(1, 8'h03, 0, 0, 1);
    checkVal("rate_three", rate, 8'd3);
    checkVal("rate_pulse", {7'd0, rate_valid}, 8'd1);
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkVal("rate_pulse_end", {7'd0, rate_valid}, 8'd0);
    while (mTs != 255 && n < 1200) begin applyStimulus(0, 8'h00, 0, 0, 1); n++; end
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkVal("rate_zero", rate, 8'd0);
    checkVal("rate_pulse2", {7'd0, rate_valid}, 8'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 2) != 0,
                    8'($urandom_range(0, 255)),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 63) == 0,
                    $urandom_range(0, 199) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spike_event_logger.md
SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 spike_in  input  1  neuron spike output, bit 0 of the neuron spike bus.
REQ-005 state_in  input  8  neuron membrane state, sampled with spike_in.
REQ-006 clr  input  1  synchronous clear of FIFO, counters and flags; active-high.
REQ-007 pop  input  1  consumer read strobe; removes the head entry.
REQ-008 evt_valid  output  1  FIFO non-empty; head entry valid.
REQ-009 evt_ts  output  8  head entry timestamp.
REQ-010 evt_state  output  8  head entry state snapshot.
REQ-011 overflow  output  1  sticky flag: an event was dropped.
REQ-012 rate  output  8  spike count of the last completed 256-cycle window.
REQ-013 rate_valid  output  1  one-cycle pulse when rate updates.

Function
REQ-014 Free-running 8-bit timestamp counter ts_cnt SHALL increment every clock; wraps 255->0.
REQ-015 Edge detect: a registered copy spk_q holds the previous spike_in sample; an event occurs at a clock edge where spike_in=1 and spk_q=0.
REQ-016 A level held high SHALL produce exactly one event; a new event requires spike_in to return low for at least one sampled cycle.
REQ-017 On an event, the entry {ts = ts_cnt value before that edge, state = state_in sampled at that edge} SHALL be written at the FIFO tail on the same edge.
REQ-018 evt_valid/evt_ts/evt_state SHALL reflect a pushed entry from the edge that writes it (1-cycle latency from sample to visibility); outputs are registered FIFO-head reads.
REQ-019 Ordering: strictly FIFO, oldest entry at head.
REQ-020 Pop: an edge with pop=1 and evt_valid=1 removes the head; pop with evt_valid=0 SHALL be ignored with no state change.
REQ-021 Push when full with no accepted pop: entry dropped, FIFO unchanged, overflow set to 1.
REQ-022 Push and accepted pop on the same edge: both performed; occupancy unchanged; overflow not set, even when full.
REQ-023 overflow SHALL remain 1 until rst_n=0 or clr=1.
REQ-024 An 8-bit window counter SHALL count events; at the edge where ts_cnt goes 255->0, rate gets that count, including an event on that same edge, and the counter restarts at 0.
REQ-025 rate_valid SHALL be 1 for exactly the cycle following each 255->0 wrap edge.
REQ-026 Max 128 events per window (edge rule); count width 8 cannot overflow; no saturation logic.
REQ-027 clr=1 at an edge: FIFO emptied, ts_cnt=0, window count=0, rate=0, rate_valid=0, overflow=0; any same-edge push or pop is discarded; spk_q still samples spike_in.
REQ-028 evt_ts/evt_state SHALL read 0 whenever evt_valid=0.

Reset
REQ-029 rst_n=0 at an edge SHALL force: all outputs 0, ts_cnt=0, window count=0, FIFO empty, spk_q=0; this overrides clr, pop and spike_in.
REQ-030 Reset mid-operation SHALL discard all stored entries; a spike_in held high through reset produces one event at the first edge after release.

Verification
REQ-031 Reset: hold rst_n=0 for 2 cycles with spike_in=1 and pop=1 -> all outputs 0; first edge after release -> evt_valid=1, evt_ts=0.
REQ-032 Single event: spike_in rises when ts_cnt=10, state_in=0x5A -> evt_valid=1, evt_ts=0x0A, evt_state=0x5A; pop for 1 cycle -> evt_valid=0, evt_ts=0.
REQ-033 Held level: spike_in high for 5 cycles, then low -> exactly one entry, and the window count increases by 1.
REQ-034 Overflow: DEPTH=4, 5 separated events with no pop -> 4 entries popped in order with ts of events 1-4, overflow=1; clr -> overflow=0, evt_valid=0.
REQ-035 Full simultaneous push and pop: FIFO full, event coincident with pop -> occupancy stays 4, overflow=0, new entry is the last entry read.
REQ-036 Rate: 3 events in window, third on the wrap edge -> rate=3 with rate_valid high for 1 cycle; next window with no events -> rate=0 and rate_valid pulses again.
